// File: rtl/count_src_pkg.sv
// Shared types and helpers for the value_count_source counter slice.
package count_src_pkg;

    localparam int VAL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] d,
                                                   input logic [VAL_W-1:0] maxv);
        return (d > maxv) ? maxv : d;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV step generator; counts only while enabled, clr restarts the period.
module tick_prescaler #(
    parameter int DIV = 50000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign step = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/value_count_source.sv
// Prescaled 0..MAXV up/down counter with load, start/stop FSM and update strobe.
// Build option: define SATURATE_EN to saturate at the limits and drop to HOLD.
module value_count_source
    import count_src_pkg::*;
#(
    parameter int DIV  = 50000000,
    parameter int MAXV = 15
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Up,
    input  logic             Load,
    input  logic [VAL_W-1:0] D,
    output logic [VAL_W-1:0] Q,
    output logic             Tick,
    output logic             Running
);

    localparam logic [VAL_W-1:0] MAX_Q = VAL_W'(MAXV);

    state_t           state;
    state_t           state_next;
    logic             start_q;
    logic             start_rise;
    logic             step;
    logic             at_limit;
    logic             sat_stop;
    logic             prescale_clr;
    logic [VAL_W-1:0] step_val;

    assign start_rise = Start & ~start_q;
    assign Running    = (state == RUN);

    always_comb begin
        at_limit = 1'b0;
        step_val = Q;
        if (Up) begin
            at_limit = (Q == MAX_Q);
            step_val = at_limit ? '0 : Q + 1'b1;
        end else begin
            at_limit = (Q == '0);
            step_val = at_limit ? MAX_Q : Q - 1'b1;
        end
    end

`ifdef SATURATE_EN
    // A load in the same cycle discards the step, so it cannot saturate.
    assign sat_stop = step & at_limit & ~Load;
`else
    assign sat_stop = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_rise && !Stop) state_next = RUN;
            RUN:  if (Stop || sat_stop)    state_next = HOLD;
            HOLD: begin
                if (start_rise && !Stop) state_next = RUN;
                else if (Load)           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Restarting the period on RUN entry makes the first step land DIV cycles later.
    assign prescale_clr = Load | ((state != RUN) && (state_next == RUN));

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (CLOCK_50),
        .resetn (Resetn),
        .en     (Running),
        .clr    (prescale_clr),
        .step   (step)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state   <= IDLE;
            start_q <= 1'b0;
            Q       <= '0;
            Tick    <= 1'b0;
        end else begin
            state   <= state_next;
            start_q <= Start;
            Tick    <= 1'b0;
            if (Load) begin
                Q    <= clamp_val(D, MAX_Q);
                Tick <= 1'b1;
            end else if (step && !sat_stop) begin
                Q    <= step_val;
                Tick <= 1'b1;
            end
        end
    end

endmodule
